// File: rtl/parking_pkg.sv
// Shared types, default capacities and reservation schedule for the parking controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package parking_pkg;

  // Car class, also used as the index into the per-class count/flag arrays
  typedef enum logic {
    CLS_PUB = 1'b0,
    CLS_UNI = 1'b1
  } cls_e;

  localparam int unsigned DEF_TOTAL_CAP     = 700;
  localparam int unsigned DEF_UNI_BASE      = 500;
  localparam int unsigned DEF_UNI_STEP      = 50;
  localparam int unsigned DEF_UNI_MIN       = 200;
  localparam int unsigned DEF_START_HR      = 8;
  localparam int unsigned DEF_STEP_START_HR = 13;
  localparam int unsigned DEF_HOUR_CYCLES   = 3600;
  localparam int unsigned DEF_CNT_W         = 11;

  localparam int unsigned     HR_W      = 5;
  localparam logic [HR_W-1:0] LAST_HOUR = 5'd23;

  // University reservation for a given hour; signed math so a long window
  // cannot underflow before the floor is applied.
  function automatic int uni_cap_f(input int hour_v, input int base, input int step,
                                   input int min_cap, input int step_start);
    int cap;
    if (hour_v < step_start) begin
      cap = base;
    end else begin
      cap = base - step * (hour_v - step_start + 1);
      if (cap < min_cap) cap = min_cap;
    end
    return cap;
  endfunction

  // Hour following h on a 24-hour dial
  function automatic logic [HR_W-1:0] next_hour(input logic [HR_W-1:0] h);
    logic [HR_W-1:0] n;
    if (h == LAST_HOUR) n = '0;
    else                n = h + HR_W'(1);
    return n;
  endfunction

endpackage

// File: rtl/parking_clock.sv
// Time-of-day counter: cycles within the hour and hour of day, with a wrap strobe.
// Latency: hour_o registered; hour_tick_o is combinational, high in the cycle whose edge advances the hour.
// Backpressure: none, free-running.
module parking_clock
  import parking_pkg::*;
#(
  parameter int unsigned HOUR_CYCLES = DEF_HOUR_CYCLES,
  parameter int unsigned START_HR    = DEF_START_HR
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [HR_W-1:0] hour_o,
  output logic            hour_tick_o
);

  localparam int unsigned      CYC_W    = $clog2(HOUR_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(HOUR_CYCLES - 1);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [HR_W-1:0]  hour_q, hour_d;

  // Advance the cycle counter; on its last count wrap it and step the hour
  always_comb begin
    hour_tick_o = (cyc_q == CYC_LAST);
    cyc_d       = cyc_q + CYC_W'(1);
    hour_d      = hour_q;
    if (hour_tick_o) begin
      cyc_d  = '0;
      hour_d = next_hour(hour_q);
    end
  end

  // Counter state with synchronous reset to the start of the configured hour
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cyc_q  <= '0;
      hour_q <= HR_W'(START_HR);
    end else begin
      cyc_q  <= cyc_d;
      hour_q <= hour_d;
    end
  end

  assign hour_o = hour_q;

endmodule

// File: rtl/parking_controller.sv
// Two-class (university/public) lot occupancy with an hourly shrinking university reservation.
// Latency: one cycle; a request sampled at an edge is reflected in counts, vacancies and flags after it.
// Backpressure: none; a request that cannot be honoured is dropped and flagged for one cycle.
module parking_controller
  import parking_pkg::*;
#(
  parameter int unsigned TOTAL_CAP     = DEF_TOTAL_CAP,
  parameter int unsigned UNI_BASE      = DEF_UNI_BASE,
  parameter int unsigned UNI_STEP      = DEF_UNI_STEP,
  parameter int unsigned UNI_MIN       = DEF_UNI_MIN,
  parameter int unsigned START_HR      = DEF_START_HR,
  parameter int unsigned STEP_START_HR = DEF_STEP_START_HR,
  parameter int unsigned HOUR_CYCLES   = DEF_HOUR_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ci,
  input  logic             uci,
  input  logic             ce,
  input  logic             uce,
  output logic [CNT_W-1:0] upc,
  output logic [CNT_W-1:0] pc,
  output logic [CNT_W-1:0] uvs,
  output logic [CNT_W-1:0] vs,
  output logic             uivs,
  output logic             ivs,
  output logic [HR_W-1:0]  hour
);

  // Two guard bits: differences of three counts stay representable and signed
  localparam int unsigned             AW      = CNT_W + 2;
  localparam logic signed [AW-1:0]    TOTAL_S = AW'(TOTAL_CAP);
  localparam int                      UVS_RST_I = uni_cap_f(int'(START_HR), int'(UNI_BASE),
                                                  int'(UNI_STEP), int'(UNI_MIN),
                                                  int'(STEP_START_HR));
  localparam logic [CNT_W-1:0]        UVS_RST = CNT_W'(UVS_RST_I);
  localparam logic [CNT_W-1:0]        VS_RST  = CNT_W'(int'(TOTAL_CAP) - UVS_RST_I);

  // Clamp a signed intermediate into the unsigned count range
  function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [AW-1:0] x);
    logic [CNT_W-1:0] r;
    if (x[AW-1])              r = '0;
    else if (|x[AW-2:CNT_W])  r = '1;
    else                      r = x[CNT_W-1:0];
    return r;
  endfunction

  // Strictly positive test on a signed intermediate
  function automatic logic is_pos(input logic signed [AW-1:0] x);
    return ~x[AW-1] & (|x);
  endfunction

  logic [HR_W-1:0] hour_cur;
  logic [HR_W-1:0] hour_eff;
  logic            hour_tick;

  logic signed [AW-1:0] cap_s;

  logic [1:0]       entry_req, exit_req;
  logic [1:0]       room;
  logic [1:0]       flag_d, flag_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_x [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic signed [AW-1:0] uni_x_s, pub_x_s, uni_left_s, pub_left_s, occ_s;
  logic signed [AW-1:0] uni_d_s, pub_d_s, uvs_s, vs_s;
  logic [CNT_W-1:0]     uvs_d, uvs_q, vs_d, vs_q;

  parking_clock #(
    .HOUR_CYCLES (HOUR_CYCLES),
    .START_HR    (START_HR)
  ) u_clock (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .hour_o      (hour_cur),
    .hour_tick_o (hour_tick)
  );

  assign hour = hour_cur;

  // Hour in force after this edge: a request coinciding with an hour change sees the new reservation
  always_comb begin
    hour_eff = hour_cur;
    if (hour_tick) hour_eff = next_hour(hour_cur);
  end

  assign cap_s = AW'(uni_cap_f(int'(hour_eff), int'(UNI_BASE), int'(UNI_STEP),
                               int'(UNI_MIN), int'(STEP_START_HR)));

  assign entry_req[CLS_UNI] = uci;
  assign entry_req[CLS_PUB] = ci;
  assign exit_req[CLS_UNI]  = uce;
  assign exit_req[CLS_PUB]  = ce;

  // Per-class update: exit first, then entry judged against the post-exit occupancy
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      flag_d[c] = 1'b0;
      cnt_x[c]  = cnt_q[c];
      if (exit_req[c]) begin
        if (cnt_q[c] == '0) flag_d[c] = 1'b1;
        else                cnt_x[c]  = cnt_q[c] - CNT_W'(1);
      end
    end

    uni_x_s    = $signed({2'b00, cnt_x[CLS_UNI]});
    pub_x_s    = $signed({2'b00, cnt_x[CLS_PUB]});
    uni_left_s = cap_s - uni_x_s;
    // University cars above a shrunken reservation still occupy real spaces
    occ_s      = (uni_x_s > cap_s) ? uni_x_s : cap_s;
    pub_left_s = TOTAL_S - occ_s - pub_x_s;

    room[CLS_UNI] = is_pos(uni_left_s);
    room[CLS_PUB] = is_pos(pub_left_s);

    for (int c = 0; c < 2; c++) begin
      cnt_d[c] = cnt_x[c];
      if (entry_req[c]) begin
        if (room[c]) cnt_d[c]  = cnt_x[c] + CNT_W'(1);
        else         flag_d[c] = 1'b1;
      end
    end
  end

  // Vacancy figures for the post-update occupancy and current reservation
  always_comb begin
    uni_d_s = $signed({2'b00, cnt_d[CLS_UNI]});
    pub_d_s = $signed({2'b00, cnt_d[CLS_PUB]});
    uvs_s   = cap_s - uni_d_s;
    if (uvs_s[AW-1]) uvs_s = '0;
    vs_s    = TOTAL_S - uni_d_s - pub_d_s - uvs_s;
    uvs_d   = sat_cnt(uvs_s);
    vs_d    = sat_cnt(vs_s);
  end

  // Output registers; reset shows an empty lot at the start-hour reservation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q[CLS_UNI] <= '0;
      cnt_q[CLS_PUB] <= '0;
      flag_q         <= '0;
      uvs_q          <= UVS_RST;
      vs_q           <= VS_RST;
    end else begin
      cnt_q[CLS_UNI] <= cnt_d[CLS_UNI];
      cnt_q[CLS_PUB] <= cnt_d[CLS_PUB];
      flag_q         <= flag_d;
      uvs_q          <= uvs_d;
      vs_q           <= vs_d;
    end
  end

  assign upc  = cnt_q[CLS_UNI];
  assign pc   = cnt_q[CLS_PUB];
  assign uvs  = uvs_q;
  assign vs   = vs_q;
  assign uivs = flag_q[CLS_UNI];
  assign ivs  = flag_q[CLS_PUB];

endmodule
